// File: rtl/tick_slot_scheduler.sv
// Tick-driven round-robin slot scheduler: a prescaler tick grants one requester a slot,
// released on done, request withdrawal, disable or timeout. beat toggles on every tick.
module tick_slot_scheduler #(
    parameter int N_REQ         = 4,
    parameter int TICK_DIV      = 10000000,
    parameter int TIMEOUT_TICKS = 4,
    parameter int ID_W          = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic             tick,
    output logic             beat,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout_pulse,
    output logic [ID_W-1:0]  timeout_id
);
    localparam int WC_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [31:0]       cnt;
    logic [WC_W-1:0]   wait_cnt;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   gid;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    int                idx;

    assign tick = (cnt == 32'(TICK_DIV)) && enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            beat <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
        end else begin
            cnt <= (cnt == 32'(TICK_DIV)) ? '0 : cnt + 32'd1;
            if (tick) beat <= ~beat;
        end
    end

    // Round-robin search starting one past the last serviced requester.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_id) + i) % N_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            busy          <= 1'b0;
            gid           <= '0;
            wait_cnt      <= '0;
            last_id       <= ID_W'(N_REQ - 1);
            timeout_pulse <= 1'b0;
            timeout_id    <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && win_vld) begin
                        grant    <= N_REQ'(1) << win_id;
                        gid      <= win_id;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // Disable aborts silently and keeps fairness pointer untouched.
                    if (!enable) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (done[gid] || !req[gid]) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        last_id <= gid;
                        state   <= IDLE;
                    end else if (tick && (wait_cnt == WC_W'(TIMEOUT_TICKS - 1))) begin
                        grant         <= '0;
                        busy          <= 1'b0;
                        last_id       <= gid;
                        timeout_pulse <= 1'b1;
                        timeout_id    <= gid;
                        state         <= IDLE;
                    end else if (tick) begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
